// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter and its neighbours.
package alu_arbiter_pkg;

  // ALU command issued with each operation.
  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } AluCtrl;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOAD,
    ARB_RUN,
    ARB_DONE
  } ArbState;

  // Nibble cycles the serial ALU needs for one 32-bit operation.
  localparam int ALU_NIBBLES = 8;

  // One-hot port mask for a one-bit port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bus of the ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  // Requester side, two ports
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  AluCtrl      req_ctrl [2];
  logic [31:0] req_w1   [2];
  logic [31:0] req_w2   [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic        resp_timeout;

  // Serial ALU side
  AluCtrl      alu_ctrl;
  logic [31:0] alu_w1;
  logic [31:0] alu_w2;
  logic        alu_perm_to_count;
  logic        alu_busy;
  logic [31:0] alu_result;

  modport slave (
    input  req_valid, req_ctrl, req_w1, req_w2, resp_ready, alu_busy, alu_result,
    output req_ready, resp_valid, resp_result, resp_timeout,
           alu_ctrl, alu_w1, alu_w2, alu_perm_to_count
  );

  modport master (
    output req_valid, req_ctrl, req_w1, req_w2, resp_ready, alu_busy, alu_result,
    input  req_ready, resp_valid, resp_result, resp_timeout,
           alu_ctrl, alu_w1, alu_w2, alu_perm_to_count
  );

endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_pick2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Resolve the grant index from the current requests and the last winner.
  always_comb begin
    any   = valid[0] | valid[1];
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~last;
    end else if (valid[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the nibble-serial ALU between the execute path (port 0) and the
// load/store address generator (port 1). One operation in flight: accept,
// load operands, run the ALU count-enable until busy falls (or give up after
// TIMEOUT run cycles), then hand the result back to the issuing port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NIBBLES = ALU_NIBBLES,
  parameter int TIMEOUT = 2 * NIBBLES + 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT - 1);

  ArbState     state_reg;
  logic        last_reg;
  logic        owner_reg;
  logic [RW-1:0] run_cnt_reg;
  AluCtrl      alu_ctrl_reg;
  logic [31:0] alu_w1_reg;
  logic [31:0] alu_w2_reg;
  logic        perm_reg;
  logic [1:0]  resp_valid_reg;
  logic [31:0] resp_result_reg;
  logic        resp_timeout_reg;

  logic        grant;
  logic        any;
  logic [1:0]  req_ready;
  logic        accept;

  rr_pick2 u_pick (
    .valid (bus.req_valid),
    .last  (last_reg),
    .grant (grant),
    .any   (any)
  );

  // Offer the round-robin grant only while idle and out of reset.
  always_comb begin
    req_ready = 2'b00;
    if (state_reg == ARB_IDLE && !rst && any) begin
      req_ready = port_onehot(grant);
    end
  end

  assign accept = |(bus.req_valid & req_ready);

  // Sequencer: accept, load, run the ALU, then hold the response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ARB_IDLE;
      last_reg         <= 1'b1;
      owner_reg        <= 1'b0;
      run_cnt_reg      <= '0;
      alu_ctrl_reg     <= ALU_ADD;
      alu_w1_reg       <= '0;
      alu_w2_reg       <= '0;
      perm_reg         <= 1'b0;
      resp_valid_reg   <= 2'b00;
      resp_result_reg  <= '0;
      resp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (accept) begin
            alu_ctrl_reg <= bus.req_ctrl[grant];
            alu_w1_reg   <= bus.req_w1[grant];
            alu_w2_reg   <= bus.req_w2[grant];
            owner_reg    <= grant;
            last_reg     <= grant;
            state_reg    <= ARB_LOAD;
          end
        end
        ARB_LOAD: begin
          // One cycle with count-enable low so the ALU restarts its nibble index.
          run_cnt_reg <= '0;
          perm_reg    <= 1'b1;
          state_reg   <= ARB_RUN;
        end
        ARB_RUN: begin
          run_cnt_reg <= run_cnt_reg + RW'(1);
          // Busy is already high in the first run cycle, so ignore it there.
          if (run_cnt_reg != '0 && !bus.alu_busy) begin
            resp_result_reg  <= bus.alu_result;
            resp_timeout_reg <= 1'b0;
            perm_reg         <= 1'b0;
            resp_valid_reg   <= port_onehot(owner_reg);
            state_reg        <= ARB_DONE;
          end else if (run_cnt_reg == RUN_LAST) begin
            resp_result_reg  <= '0;
            resp_timeout_reg <= 1'b1;
            perm_reg         <= 1'b0;
            resp_valid_reg   <= port_onehot(owner_reg);
            state_reg        <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          // Only the owner's ready releases the response.
          if (bus.resp_ready[owner_reg]) begin
            resp_valid_reg <= 2'b00;
            state_reg      <= ARB_IDLE;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready         = req_ready;
  assign bus.resp_valid        = resp_valid_reg;
  assign bus.resp_result       = resp_result_reg;
  assign bus.resp_timeout      = resp_timeout_reg;
  assign bus.alu_ctrl          = alu_ctrl_reg;
  assign bus.alu_w1            = alu_w1_reg;
  assign bus.alu_w2            = alu_w2_reg;
  assign bus.alu_perm_to_count = perm_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed stimulus, a behavioural serial-ALU model,
// a timestamp-based reference model checked every cycle, and literal pins.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NIB   = 8;
  localparam int TMO   = 2 * NIB + 2;
  localparam int PIN_N = 512;

  logic clk;
  logic rst;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_arbiter_if bus();

  alu_arbiter #(.NIBBLES(NIB), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, advanced on each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input AluCtrl c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Behavioural serial ALU: busy for NIB cycles after count-enable rises.
  logic alu_stuck;
  int   alu_cnt = 0;
  always @(posedge clk) alu_cnt <= bus.alu_perm_to_count ? alu_cnt + 1 : 0;
  assign bus.alu_busy   = bus.alu_perm_to_count && (alu_stuck || alu_cnt < NIB);
  assign bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_w1, bus.alu_w2);

  // Literal expectations at fixed cycles, written by the stimulus.
  logic        pin_rv_en [PIN_N];
  logic [1:0]  pin_rv    [PIN_N];
  logic [31:0] pin_res   [PIN_N];
  logic        pin_to    [PIN_N];
  logic        pin_rr_en [PIN_N];
  logic [1:0]  pin_rr    [PIN_N];

  // Reference model state.
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        m_owner = 1'b0;
  int          m_acc = 0;
  int          m_done = 0;
  AluCtrl      m_ctrl = ALU_ADD;
  logic [31:0] m_w1 = '0, m_w2 = '0;
  logic [31:0] m_res_pend = '0, m_res_out = '0;
  logic        m_to_pend = 1'b0, m_to_out = 1'b0;
  logic [1:0]  exp_rr, exp_rv;
  logic        exp_perm;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Compare DUT outputs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_ctrl = ALU_ADD; m_w1 = '0; m_w2 = '0;
      m_res_out = '0; m_to_out = 1'b0;
    end
    exp_rr = 2'b00;
    if (!rst && !m_busy) begin
      if (bus.req_valid == 2'b11) exp_rr = m_last ? 2'b01 : 2'b10;
      else exp_rr = bus.req_valid;
    end
    exp_rv = 2'b00;
    exp_perm = 1'b0;
    if (m_busy) begin
      if (cyc >= m_done) begin
        exp_rv = m_owner ? 2'b10 : 2'b01;
        m_res_out = m_res_pend;
        m_to_out = m_to_pend;
      end else if (cyc >= m_acc + 2) begin
        exp_perm = 1'b1;
      end
    end

    chk("req_ready",     32'(bus.req_ready),         32'(exp_rr));
    chk("resp_valid",    32'(bus.resp_valid),        32'(exp_rv));
    chk("resp_result",   bus.resp_result,            m_res_out);
    chk("resp_timeout",  32'(bus.resp_timeout),      32'(m_to_out));
    chk("perm_to_count", 32'(bus.alu_perm_to_count), 32'(exp_perm));
    chk("alu_ctrl",      32'(bus.alu_ctrl),          32'(m_ctrl));
    chk("alu_w1",        bus.alu_w1,                 m_w1);
    chk("alu_w2",        bus.alu_w2,                 m_w2);

    if (cyc < PIN_N && pin_rr_en[cyc]) begin
      chk("pin_req_ready", 32'(bus.req_ready), 32'(pin_rr[cyc]));
    end
    if (cyc < PIN_N && pin_rv_en[cyc]) begin
      chk("pin_resp_valid",   32'(bus.resp_valid),   32'(pin_rv[cyc]));
      chk("pin_resp_result",  bus.resp_result,       pin_res[cyc]);
      chk("pin_resp_timeout", 32'(bus.resp_timeout), 32'(pin_to[cyc]));
    end

    if (!rst) begin
      if (!m_busy) begin
        if ((bus.req_valid & exp_rr) != 2'b00) begin
          m_owner = exp_rr[1];
          m_last  = exp_rr[1];
          m_ctrl  = bus.req_ctrl[m_owner];
          m_w1    = bus.req_w1[m_owner];
          m_w2    = bus.req_w2[m_owner];
          m_acc   = cyc;
          m_busy  = 1'b1;
          if (alu_stuck) begin
            m_done = cyc + 2 + TMO; m_res_pend = '0; m_to_pend = 1'b1;
          end else begin
            m_done = cyc + 3 + NIB; m_res_pend = alu_fn(m_ctrl, m_w1, m_w2); m_to_pend = 1'b0;
          end
          $display("cycle %0d: accept port %0d ctrl=%0d w1=%0d w2=%0d", cyc, m_owner, m_ctrl, m_w1, m_w2);
        end
      end else if (cyc >= m_done && bus.resp_ready[m_owner]) begin
        m_busy = 1'b0;
        $display("cycle %0d: response port %0d result=%0d timeout=%0d", cyc, m_owner, bus.resp_result, bus.resp_timeout);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin_rv_at(input int c, input logic [1:0] rv, input logic [31:0] res, input logic to);
    pin_rv_en[c] = 1'b1; pin_rv[c] = rv; pin_res[c] = res; pin_to[c] = to;
  endtask

  task automatic pin_rr_at(input int c, input logic [1:0] rr);
    pin_rr_en[c] = 1'b1; pin_rr[c] = rr;
  endtask

  task automatic set_op(input int p, input AluCtrl c, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctrl[p] = c; bus.req_w1[p] = a; bus.req_w2[p] = b;
  endtask

  int t;

  initial begin
    for (int i = 0; i < PIN_N; i++) begin
      pin_rv_en[i] = 1'b0; pin_rv[i] = 2'b00; pin_res[i] = '0; pin_to[i] = 1'b0;
      pin_rr_en[i] = 1'b0; pin_rr[i] = 2'b00;
    end
    alu_stuck = 1'b0;
    rst = 1'b1;
    bus.resp_ready = 2'b11;
    set_op(0, ALU_ADD, 10, 20);
    set_op(1, ALU_SUB, 100, 3);
    // Both ports request through reset: no ready until released.
    bus.req_valid = 2'b11;

    // Tie and alternation: grants 0, 1, 0 spaced 12 cycles apart.
    tick(3);
    rst = 1'b0;
    t = cyc;
    pin_rr_at(t, 2'b01);
    pin_rv_at(t + 11, 2'b01, 30, 1'b0);
    pin_rr_at(t + 12, 2'b10);
    pin_rv_at(t + 23, 2'b10, 97, 1'b0);
    pin_rr_at(t + 24, 2'b01);
    pin_rv_at(t + 35, 2'b01, 30, 1'b0);
    tick(25);
    bus.req_valid = 2'b00;
    tick(14);

    // Single op: 123 + 5 answered 11 cycles after accept.
    t = cyc;
    set_op(0, ALU_ADD, 123, 5);
    bus.req_valid = 2'b01;
    pin_rr_at(t, 2'b01);
    pin_rv_at(t + 10, 2'b00, 30, 1'b0);
    pin_rv_at(t + 11, 2'b01, 128, 1'b0);
    tick(1);
    bus.req_valid = 2'b00;
    tick(13);

    // Backpressure on port 1 with port 0 ready high and waiting; withdrawal.
    t = cyc;
    bus.resp_ready = 2'b01;
    set_op(1, ALU_ADD, 7, 9);
    bus.req_valid = 2'b10;
    pin_rr_at(t, 2'b10);
    for (int k = 11; k <= 16; k++) pin_rv_at(t + k, 2'b10, 16, 1'b0);
    pin_rr_at(t + 16, 2'b00);
    pin_rr_at(t + 17, 2'b01);
    pin_rr_at(t + 20, 2'b00);
    pin_rv_at(t + 28, 2'b01, 3, 1'b0);
    tick(1);
    set_op(0, ALU_ADD, 1, 2);
    bus.req_valid = 2'b01;
    tick(15);
    bus.resp_ready = 2'b11;
    tick(2);
    set_op(1, ALU_ADD, 50, 60);
    bus.req_valid = 2'b10;
    tick(4);
    bus.req_valid = 2'b00;
    tick(10);

    // Timeout: ALU never finishes.
    t = cyc;
    alu_stuck = 1'b1;
    set_op(0, ALU_ADD, 5, 5);
    bus.req_valid = 2'b01;
    pin_rr_at(t, 2'b01);
    pin_rv_at(t + 19, 2'b00, 3, 1'b0);
    pin_rv_at(t + 20, 2'b01, 0, 1'b1);
    tick(1);
    bus.req_valid = 2'b00;
    tick(21);
    alu_stuck = 1'b0;

    // Reset three cycles into RUN, then a clean op right after release.
    t = cyc;
    set_op(0, ALU_ADD, 1000, 24);
    bus.req_valid = 2'b01;
    pin_rr_at(t, 2'b01);
    pin_rv_at(t + 5, 2'b00, 0, 1'b0);
    tick(5);
    #1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t = cyc;
    pin_rr_at(t, 2'b01);
    pin_rv_at(t + 11, 2'b01, 1024, 1'b0);
    tick(1);
    bus.req_valid = 2'b00;
    tick(14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
